iter_exec_unit: RTL and testbench
=================================

// Module: iter_exec_unit
// PURPOSE
//  Parametrised, multi-cycle successor to the single-cycle execute stage.
//  Takes operands that are already resolved and an opcode over a valid/ready handshake.
//  Computes ALU, shift and rotate ops in 1 cycle, and MUL/DIV iteratively in WIDTH cycles.
//  Returns a registered result plus flags over a second valid/ready handshake; sits between decode/operand-fetch and writeback.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=4, even)
//  SHW    3  shift-amount width; must equal clog2(WIDTH)
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  in_valid     in   1        opcode/operands valid
//  in_ready     out  1        unit can accept (high only in IDLE)
//  opcode       in   5        codebase opcode encoding (list below)
//  operand_a    in   WIDTH    operand 1
//  operand_b    in   WIDTH    operand 2
//  s_r_amount   in   SHW      shift/rotate amount
//  out_valid    out  1        result/flags valid
//  out_ready    in   1        consumer accepts result
//  result       out  2*WIDTH  MUL: full product; DIV: {rem,quot}; other ops: {0,res}
//  zero_flag    out  1        see flag rules
//  carry_flag   out  1
//  ac_flag      out  1        nibble carry/borrow
//  parity_flag  out  1        XOR of flag-scope bits (1 = odd count of ones)
//  dz_flag      out  1        divide by zero
//  illegal_op   out  1        unsupported opcode
// BEHAVIOUR
//  - Reset (async): state=IDLE; result=0; all flags=0; out_valid=0; in_ready=1. Reset during BUSY abandons the op, with no output.
//  - FSM IDLE->(accept)->BUSY->DONE->(out_valid&out_ready)->IDLE.
//    Accept = in_valid&in_ready; the opcode and operands are latched on accept.
//  - Single-cycle ops: BUSY lasts 1 cycle, so out_valid rises 2 clocks after the accept edge.
//  - MUL/DIV: BUSY lasts WIDTH cycles (one bit per cycle), so out_valid rises WIDTH+1 clocks after accept.
//    MUL is shift-add; DIV is restoring.
//  - DIV with b==0: no iteration; result={a, all-ones}, dz_flag=1, single-cycle latency.
//  - DONE: result/flags held stable while out_ready=0; in_ready=0. No new accept in the cycle out_valid drops.
//  - Flags and result update only on entry to DONE; they hold their values in IDLE.
//  - Opcodes: 00000 MOV(a); 00001 ADD; 00010 SUB; 00011 MUL; 00100 DIV; 00101 INC(a); 00110 DEC(a); 00111 AND; 01000 OR; 01001 NOT(a); 01010 XOR; 01011 LDB(b);
//    10000 ASL; 10001 ASR; 10010 LSL; 10011 LSR; 10100 ROL; 10101 ROR; 11001 CMP (result[0]=a>=b, unsigned).
//    Any other opcode: result=0, illegal_op=1, other flags 0, single-cycle latency.
//  - Flag scope: MUL uses result[2W-1:0]; every other op uses result[W-1:0]. zero_flag = (scope==0).
//  - carry_flag:
//    - ADD/INC: carry out of bit W-1.
//    - SUB: borrow (a<b). DEC: borrow (a==0).
//    - Left shifts/ROL: last bit shifted out, a[W-s]. Right shifts/ROR: a[s-1].
//    - s==0: carry=0.
//    - All other ops: carry=0.
//  - ac_flag: carry/borrow out of bit 3 for ADD/SUB/INC/DEC; 0 otherwise.
//  - ASR replicates the MSB. Shifts and rotates use amount mod WIDTH; s==0 passes a unchanged.
//  - dz_flag and illegal_op are 0 except in the cases above.
// TESTING (WIDTH=8)
//  1. ADD a=F0 b=20 -> result=0010, carry=1, ac=0, zero=0. ADD 0F+01 -> 0010, ac=1, carry=0.
//     SUB 05-05 -> 0, zero=1, carry=0.
//  2. MUL FF*FF -> result=FE01, out_valid exactly 9 clocks after accept, parity=0 (FE01 has 8 ones). MUL 00*37 -> zero=1.
//  3. DIV C8/07 -> result=041C (rem 4, quot 28). DIV 2A/00 -> result=2AFF, dz_flag=1, latency 2.
//  4. Shifts: ASR 90 by 2 -> E4, carry=0. LSL 81 by 1 -> 02, carry=1. ROR 01 by 1 -> 80.
//     ROL with s=0 -> unchanged, carry=0.
//  5. Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0.
//     Back-to-back in_valid are all accepted in order, with none lost.
//  6. Reset asserted mid-MUL (cycle 4) -> immediate IDLE, outputs 0, no out_valid. Opcode 11110 -> illegal_op=1, result=0.

Source files
------------

// File: rtl/iter_exec_unit.sv
// Multi-cycle execute unit: single-cycle ALU/shift/rotate ops, iterative
// shift-add MUL and restoring DIV (one bit per cycle), with valid/ready
// handshakes on both the operand side and the result side.
module iter_exec_unit #(
   parameter int WIDTH = 8,
   parameter int SHW   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         opcode,
   input  logic [WIDTH-1:0]   operand_a,
   input  logic [WIDTH-1:0]   operand_b,
   input  logic [SHW-1:0]     s_r_amount,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               zero_flag,
   output logic               carry_flag,
   output logic               ac_flag,
   output logic               parity_flag,
   output logic               dz_flag,
   output logic               illegal_op
);

   localparam logic [4:0] OP_MOV = 5'b00000;
   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_SUB = 5'b00010;
   localparam logic [4:0] OP_MUL = 5'b00011;
   localparam logic [4:0] OP_DIV = 5'b00100;
   localparam logic [4:0] OP_INC = 5'b00101;
   localparam logic [4:0] OP_DEC = 5'b00110;
   localparam logic [4:0] OP_AND = 5'b00111;
   localparam logic [4:0] OP_OR  = 5'b01000;
   localparam logic [4:0] OP_NOT = 5'b01001;
   localparam logic [4:0] OP_XOR = 5'b01010;
   localparam logic [4:0] OP_LDB = 5'b01011;
   localparam logic [4:0] OP_ASL = 5'b10000;
   localparam logic [4:0] OP_ASR = 5'b10001;
   localparam logic [4:0] OP_LSL = 5'b10010;
   localparam logic [4:0] OP_LSR = 5'b10011;
   localparam logic [4:0] OP_ROL = 5'b10100;
   localparam logic [4:0] OP_ROR = 5'b10101;
   localparam logic [4:0] OP_CMP = 5'b11001;

   localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   // Odd-parity indicator over the flag scope
   function automatic logic parity_f(input logic [2*WIDTH-1:0] v);
      parity_f = ^v;
   endfunction

   state_t               state_r, state_s;
   logic [4:0]           op_r;
   logic [WIDTH-1:0]     a_r, b_r;
   logic [SHW-1:0]       amt_r, cnt_r;
   logic [2*WIDTH-1:0]   acc_r, acc_nxt_s;
   logic [2*WIDTH-1:0]   result_r, fin_res_s, scope_s;
   logic                 out_valid_r, zero_r, carry_r, ac_r, parity_r, dz_r, ill_r;
   logic                 fin_carry_s, fin_ac_s, fin_dz_s, fin_ill_s;
   logic                 accept_s, iter_s, last_s, done_hs_s;
   logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
   logic [WIDTH:0]       a_x_s, b_x_s, add_s, sub_s, inc_s, dec_s, shl_s, shr_s;

   assign in_ready    = (state_r == S_IDLE);
   assign accept_s    = in_valid & in_ready;
   // DIV by zero skips iteration and finishes in one BUSY cycle
   assign iter_s      = (op_r == OP_MUL) | ((op_r == OP_DIV) & (b_r != {WIDTH{1'b0}}));
   assign last_s      = (cnt_r == LAST_CNT);
   assign done_hs_s   = out_valid_r & out_ready;

   assign out_valid   = out_valid_r;
   assign result      = result_r;
   assign zero_flag   = zero_r;
   assign carry_flag  = carry_r;
   assign ac_flag     = ac_r;
   assign parity_flag = parity_r;
   assign dz_flag     = dz_r;
   assign illegal_op  = ill_r;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE:  if (accept_s) state_s = S_BUSY; else state_s = S_IDLE;
         S_BUSY:  if (!iter_s || last_s) state_s = S_DONE; else state_s = S_BUSY;
         S_DONE:  if (done_hs_s) state_s = S_IDLE; else state_s = S_DONE;
         default: state_s = S_IDLE;
      endcase
   end

   // One MUL (shift-add) or DIV (restoring) step; acc holds {hi,lo} / {rem,quot}
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                    (acc_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
      div_shift_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
      div_diff_s  = div_shift_s - {1'b0, b_r};
      acc_nxt_s   = acc_r;
      if (op_r == OP_MUL) begin
         acc_nxt_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else if (!div_diff_s[WIDTH]) begin
         acc_nxt_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
         acc_nxt_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
   end

   // Final result and flags for the op finishing this BUSY cycle
   always_comb begin
      a_x_s       = {1'b0, a_r};
      b_x_s       = {1'b0, b_r};
      add_s       = a_x_s + b_x_s;
      sub_s       = a_x_s - b_x_s;
      inc_s       = a_x_s + {{WIDTH{1'b0}}, 1'b1};
      dec_s       = a_x_s - {{WIDTH{1'b0}}, 1'b1};
      // shl_s[WIDTH] is the last bit shifted out left, shr_s[0] the last out right
      shl_s       = a_x_s << amt_r;
      shr_s       = {a_r, 1'b0} >> amt_r;
      fin_res_s   = {(2*WIDTH){1'b0}};
      fin_carry_s = 1'b0;
      fin_ac_s    = 1'b0;
      fin_dz_s    = 1'b0;
      fin_ill_s   = 1'b0;
      case (op_r)
         OP_MOV: fin_res_s = {{WIDTH{1'b0}}, a_r};
         OP_ADD: begin
            fin_res_s   = {{WIDTH{1'b0}}, add_s[WIDTH-1:0]};
            fin_carry_s = add_s[WIDTH];
            fin_ac_s    = add_s[4] ^ a_x_s[4] ^ b_x_s[4];
         end
         OP_SUB: begin
            fin_res_s   = {{WIDTH{1'b0}}, sub_s[WIDTH-1:0]};
            fin_carry_s = sub_s[WIDTH];
            fin_ac_s    = sub_s[4] ^ a_x_s[4] ^ b_x_s[4];
         end
         OP_MUL: fin_res_s = acc_nxt_s;
         OP_DIV: begin
            if (b_r == {WIDTH{1'b0}}) begin
               fin_res_s = {a_r, {WIDTH{1'b1}}};
               fin_dz_s  = 1'b1;
            end else begin
               fin_res_s = acc_nxt_s;
            end
         end
         OP_INC: begin
            fin_res_s   = {{WIDTH{1'b0}}, inc_s[WIDTH-1:0]};
            fin_carry_s = inc_s[WIDTH];
            fin_ac_s    = inc_s[4] ^ a_x_s[4];
         end
         OP_DEC: begin
            fin_res_s   = {{WIDTH{1'b0}}, dec_s[WIDTH-1:0]};
            fin_carry_s = dec_s[WIDTH];
            fin_ac_s    = dec_s[4] ^ a_x_s[4];
         end
         OP_AND: fin_res_s = {{WIDTH{1'b0}}, a_r & b_r};
         OP_OR:  fin_res_s = {{WIDTH{1'b0}}, a_r | b_r};
         OP_NOT: fin_res_s = {{WIDTH{1'b0}}, ~a_r};
         OP_XOR: fin_res_s = {{WIDTH{1'b0}}, a_r ^ b_r};
         OP_LDB: fin_res_s = {{WIDTH{1'b0}}, b_r};
         OP_ASL, OP_LSL: begin
            fin_res_s   = {{WIDTH{1'b0}}, shl_s[WIDTH-1:0]};
            fin_carry_s = shl_s[WIDTH];
         end
         OP_ASR: begin
            fin_res_s   = {{WIDTH{1'b0}}, WIDTH'($signed(a_r) >>> amt_r)};
            fin_carry_s = shr_s[0];
         end
         OP_LSR: begin
            fin_res_s   = {{WIDTH{1'b0}}, shr_s[WIDTH:1]};
            fin_carry_s = shr_s[0];
         end
         OP_ROL: begin
            fin_res_s   = {{WIDTH{1'b0}}, WIDTH'(({a_r, a_r} << amt_r) >> WIDTH)};
            fin_carry_s = shl_s[WIDTH];
         end
         OP_ROR: begin
            fin_res_s   = {{WIDTH{1'b0}}, WIDTH'({a_r, a_r} >> amt_r)};
            fin_carry_s = shr_s[0];
         end
         OP_CMP: fin_res_s = {{(2*WIDTH-1){1'b0}}, ~sub_s[WIDTH]};
         default: fin_ill_s = 1'b1;
      endcase
      // MUL flags cover the full product, everything else the low half
      if (op_r == OP_MUL) begin
         scope_s = fin_res_s;
      end else begin
         scope_s = {{WIDTH{1'b0}}, fin_res_s[WIDTH-1:0]};
      end
   end

   // Operand latch, iteration state and registered result/flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r        <= 5'b00000;
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         amt_r       <= {SHW{1'b0}};
         cnt_r       <= {SHW{1'b0}};
         acc_r       <= {(2*WIDTH){1'b0}};
         result_r    <= {(2*WIDTH){1'b0}};
         out_valid_r <= 1'b0;
         zero_r      <= 1'b0;
         carry_r     <= 1'b0;
         ac_r        <= 1'b0;
         parity_r    <= 1'b0;
         dz_r        <= 1'b0;
         ill_r       <= 1'b0;
      end else begin
         if (accept_s) begin
            op_r  <= opcode;
            a_r   <= operand_a;
            b_r   <= operand_b;
            amt_r <= s_r_amount;
            cnt_r <= {SHW{1'b0}};
            acc_r <= (opcode == OP_MUL) ? {{WIDTH{1'b0}}, operand_b}
                                        : {{WIDTH{1'b0}}, operand_a};
         end else if ((state_r == S_BUSY) && iter_s) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + SHW'(1'b1);
         end
         if ((state_r == S_BUSY) && (state_s == S_DONE)) begin
            result_r <= fin_res_s;
            zero_r   <= ~fin_ill_s & (scope_s == {(2*WIDTH){1'b0}});
            carry_r  <= fin_carry_s;
            ac_r     <= fin_ac_s;
            parity_r <= parity_f(scope_s);
            dz_r     <= fin_dz_s;
            ill_r    <= fin_ill_s;
         end
         // out_valid follows DONE entry by one clock and drops on handshake
         out_valid_r <= (state_r == S_DONE) & ~done_hs_s;
      end
   end

endmodule

// File: tb/tb_iter_exec_unit.sv
// Directed self-checking bench for iter_exec_unit (WIDTH=8).
module tb_iter_exec_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  opcode = 5'b00000;
   logic [7:0]  operand_a = 8'h00;
   logic [7:0]  operand_b = 8'h00;
   logic [2:0]  s_r_amount = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] result;
   logic        zero_flag, carry_flag, ac_flag, parity_flag, dz_flag, illegal_op;

   int n_checks = 0;
   int n_fails  = 0;

   iter_exec_unit #(.WIDTH(8), .SHW(3)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
      .s_r_amount(s_r_amount), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
      .ac_flag(ac_flag), .parity_flag(parity_flag), .dz_flag(dz_flag),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] flags();
      return {zero_flag, carry_flag, ac_flag, parity_flag, dz_flag, illegal_op};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one op, count clocks from the accept edge to out_valid
   task automatic issue(input string tag, input logic [4:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [2:0] s, output int lat);
      @(negedge clk);
      check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; opcode = op; operand_a = a; operand_b = b; s_r_amount = s;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   // Flags packed as {zero, carry, ac, parity, dz, illegal}
   task automatic expect_op(input string tag, input logic [4:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [2:0] s, input logic [15:0] er,
                            input int el, input logic [5:0] ef);
      int lat;
      issue(tag, op, a, b, s, lat);
      check_eq({tag, "_lat"},   32'(lat),    32'(el));
      check_eq({tag, "_res"},   32'(result), 32'(er));
      check_eq({tag, "_flags"}, 32'(flags()), 32'(ef));
      @(posedge clk);
      #1;
      check_eq({tag, "_drop"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_hold"}, 32'(result),    32'(er));
   endtask

   logic [4:0]  b2b_op  [4];
   logic [7:0]  b2b_a   [4];
   logic [7:0]  b2b_b   [4];
   logic [15:0] b2b_exp [4];

   initial begin
      int lat;
      int got;
      int guard;
      logic seen;

      #12;
      check_eq("rst_in_ready",  32'(in_ready),  32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_result",    32'(result),    32'd0);
      check_eq("rst_flags",     32'(flags()),   32'd0);
      @(negedge clk) reset = 1'b0;

      expect_op("add_f0_20", 5'b00001, 8'hF0, 8'h20, 3'd0, 16'h0010, 2, 6'b010100);
      expect_op("add_0f_01", 5'b00001, 8'h0F, 8'h01, 3'd0, 16'h0010, 2, 6'b001100);
      expect_op("sub_05_05", 5'b00010, 8'h05, 8'h05, 3'd0, 16'h0000, 2, 6'b100000);
      expect_op("sub_10_01", 5'b00010, 8'h10, 8'h01, 3'd0, 16'h000F, 2, 6'b001000);
      expect_op("sub_01_02", 5'b00010, 8'h01, 8'h02, 3'd0, 16'h00FF, 2, 6'b011000);
      expect_op("inc_ff",    5'b00101, 8'hFF, 8'h00, 3'd0, 16'h0000, 2, 6'b111000);
      expect_op("dec_00",    5'b00110, 8'h00, 8'h00, 3'd0, 16'h00FF, 2, 6'b011000);
      expect_op("mul_ff_ff", 5'b00011, 8'hFF, 8'hFF, 3'd0, 16'hFE01, 9, 6'b000000);
      expect_op("mul_00_37", 5'b00011, 8'h00, 8'h37, 3'd0, 16'h0000, 9, 6'b100000);
      expect_op("mul_0d_0b", 5'b00011, 8'h0D, 8'h0B, 3'd0, 16'h008F, 9, 6'b000100);
      expect_op("div_c8_07", 5'b00100, 8'hC8, 8'h07, 3'd0, 16'h041C, 9, 6'b000100);
      expect_op("div_ff_10", 5'b00100, 8'hFF, 8'h10, 3'd0, 16'h0F0F, 9, 6'b000000);
      expect_op("div_2a_00", 5'b00100, 8'h2A, 8'h00, 3'd0, 16'h2AFF, 2, 6'b000010);
      expect_op("asr_90_2",  5'b10001, 8'h90, 8'h00, 3'd2, 16'h00E4, 2, 6'b000000);
      expect_op("lsl_81_1",  5'b10010, 8'h81, 8'h00, 3'd1, 16'h0002, 2, 6'b010100);
      expect_op("asl_41_2",  5'b10000, 8'h41, 8'h00, 3'd2, 16'h0004, 2, 6'b010100);
      expect_op("lsr_81_3",  5'b10011, 8'h81, 8'h00, 3'd3, 16'h0010, 2, 6'b000100);
      expect_op("ror_01_1",  5'b10101, 8'h01, 8'h00, 3'd1, 16'h0080, 2, 6'b010100);
      expect_op("rol_5a_0",  5'b10100, 8'h5A, 8'h00, 3'd0, 16'h005A, 2, 6'b000000);
      expect_op("rol_81_1",  5'b10100, 8'h81, 8'h00, 3'd1, 16'h0003, 2, 6'b010000);
      expect_op("xor_5a_ff", 5'b01010, 8'h5A, 8'hFF, 3'd0, 16'h00A5, 2, 6'b000000);
      expect_op("and_f0_3c", 5'b00111, 8'hF0, 8'h3C, 3'd0, 16'h0030, 2, 6'b000000);
      expect_op("or_0f_30",  5'b01000, 8'h0F, 8'h30, 3'd0, 16'h003F, 2, 6'b000000);
      expect_op("not_0f",    5'b01001, 8'h0F, 8'h00, 3'd0, 16'h00F0, 2, 6'b000000);
      expect_op("ldb_3c",    5'b01011, 8'h00, 8'h3C, 3'd0, 16'h003C, 2, 6'b000000);
      expect_op("mov_80",    5'b00000, 8'h80, 8'h11, 3'd0, 16'h0080, 2, 6'b000100);
      expect_op("cmp_05_07", 5'b11001, 8'h05, 8'h07, 3'd0, 16'h0000, 2, 6'b100000);
      expect_op("cmp_07_05", 5'b11001, 8'h07, 8'h05, 3'd0, 16'h0001, 2, 6'b000100);

      // Backpressure: hold out_ready low for 5 cycles after out_valid
      out_ready = 1'b0;
      issue("bp", 5'b00001, 8'h0F, 8'h01, 3'd0, lat);
      check_eq("bp_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid",    32'(out_valid), 32'd1);
         check_eq("bp_in_ready", 32'(in_ready),  32'd0);
         check_eq("bp_res",      32'(result),    32'h0010);
         check_eq("bp_flags",    32'(flags()),   32'(6'b001100));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check_eq("bp_drop", 32'(out_valid), 32'd0);
      check_eq("bp_idle", 32'(in_ready),  32'd1);

      // Back-to-back requests with in_valid held high throughout
      b2b_op[0] = 5'b00001; b2b_a[0] = 8'h01; b2b_b[0] = 8'h02; b2b_exp[0] = 16'h0003;
      b2b_op[1] = 5'b00011; b2b_a[1] = 8'h03; b2b_b[1] = 8'h05; b2b_exp[1] = 16'h000F;
      b2b_op[2] = 5'b01010; b2b_a[2] = 8'hF0; b2b_b[2] = 8'h0F; b2b_exp[2] = 16'h00FF;
      b2b_op[3] = 5'b00100; b2b_a[3] = 8'h09; b2b_b[3] = 8'h02; b2b_exp[3] = 16'h0104;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               in_valid = 1'b1; opcode = b2b_op[i]; operand_a = b2b_a[i]; operand_b = b2b_b[i];
               guard = 0;
               while (!in_ready && guard < 50) begin
                  @(negedge clk);
                  guard++;
               end
               @(posedge clk);
            end
            #1 in_valid = 1'b0;
         end
         begin
            got = 0;
            for (int c = 0; c < 200 && got < 4; c++) begin
               @(negedge clk);
               if (out_valid) begin
                  check_eq("b2b_res", 32'(result), 32'(b2b_exp[got]));
                  got++;
               end
            end
            check_eq("b2b_count", 32'(got), 32'd4);
         end
      join
      @(posedge clk);
      #1;

      // Reset during the 4th MUL iteration abandons the op
      expect_op("pre_rst", 5'b00001, 8'hF0, 8'h20, 3'd0, 16'h0010, 2, 6'b010100);
      @(negedge clk);
      in_valid = 1'b1; opcode = 5'b00011; operand_a = 8'hFF; operand_b = 8'hFF;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
      check_eq("mid_rst_ready", 32'(in_ready),  32'd1);
      check_eq("mid_rst_res",   32'(result),    32'd0);
      check_eq("mid_rst_flags", 32'(flags()),   32'd0);
      @(negedge clk) reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check_eq("mid_rst_no_valid", 32'(seen), 32'd0);

      expect_op("illegal_1e", 5'b11110, 8'h12, 8'h34, 3'd0, 16'h0000, 2, 6'b000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
